// File: rtl/rom_load_sequencer_if.sv
// Avalon-MM register port between the NIOS II master and the ROM load sequencer.
interface rom_load_sequencer_if;
  logic [1:0]  AVL_ADDR;
  logic        AVL_CS;
  logic        AVL_WRITE;
  logic        AVL_READ;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;

  modport master (
    output AVL_ADDR, AVL_CS, AVL_WRITE, AVL_READ, AVL_WRITEDATA,
    input  AVL_READDATA, AVL_WAITREQUEST
  );

  modport slave (
    input  AVL_ADDR, AVL_CS, AVL_WRITE, AVL_READ, AVL_WRITEDATA,
    output AVL_READDATA, AVL_WAITREQUEST
  );
endinterface

// File: rtl/rom_load_sequencer.sv
// Serialises 32-bit Avalon words into paced PRG/CHR ROM byte writes and
// holds the NES core in reset for the duration of a cartridge load session.
module rom_load_sequencer #(
  parameter int unsigned WR_GAP        = 0,
  parameter int unsigned RELEASE_DELAY = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  rom_load_sequencer_if.slave   avl,
  output logic [15:0]           ROM_ADDR,
  output logic [7:0]            ROM_DATA,
  output logic                  PRG_ROM_WRITE,
  output logic                  CHR_ROM_WRITE,
  output logic                  mirroring_mode,
  output logic                  is_chr_ram,
  output logic                  NES_HOLD,
  output logic                  LOAD_DONE
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic        NO_GAP = (WR_GAP == 0);

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_BASE = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADING,
    S_DRAIN,
    S_GAP,
    S_RELEASE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                target_q;
  logic [DATA_W-1:0]   word_q;
  logic [1:0]          byte_idx_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [CNT_W-1:0]    rel_cnt_q;
  logic                err_q;
  logic                wrap_q;
  logic                waitreq_q;
  logic                prg_q;
  logic                chr_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [7:0]          rom_data_q;
  logic                mirror_q;
  logic                chr_ram_q;
  logic                hold_q;
  logic                done_q;

  logic                wr_c;
  logic                ctrl_wr_c;
  logic                base_wr_c;
  logic                data_wr_c;
  logic                start_c;
  logic                done_cmd_c;
  logic [1:0]          next_idx_c;
  logic                emit_c;
  logic [7:0]          emit_byte_c;

  // Access decode; nothing is accepted while the byte buffer is occupied.
  always_comb begin
    wr_c       = avl.AVL_CS & avl.AVL_WRITE & ~waitreq_q;
    ctrl_wr_c  = wr_c & (avl.AVL_ADDR == REG_CTRL);
    base_wr_c  = wr_c & (avl.AVL_ADDR == REG_BASE);
    data_wr_c  = wr_c & (avl.AVL_ADDR == REG_DATA);
    start_c    = ctrl_wr_c & avl.AVL_WRITEDATA[0];
    done_cmd_c = ctrl_wr_c & avl.AVL_WRITEDATA[1] & ~avl.AVL_WRITEDATA[0];
  end

  // Decide whether a byte strobe is launched at this edge and which byte it carries.
  always_comb begin
    next_idx_c  = byte_idx_q + 2'd1;
    emit_c      = 1'b0;
    emit_byte_c = 8'(word_q >> {next_idx_c, 3'b000});
    case (state_q)
      S_LOADING: begin
        if (data_wr_c) begin
          emit_c      = 1'b1;
          emit_byte_c = avl.AVL_WRITEDATA[7:0];
        end
      end
      S_DRAIN: emit_c = (byte_idx_q != 2'd3) && NO_GAP;
      S_GAP:   emit_c = (gap_cnt_q == GAP_W'(1));
      default: emit_c = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      target_q   <= 1'b0;
      word_q     <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      waitreq_q  <= 1'b0;
      prg_q      <= 1'b0;
      chr_q      <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      mirror_q   <= 1'b0;
      chr_ram_q  <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      prg_q <= 1'b0;
      chr_q <= 1'b0;

      // One byte strobe; the address post-increments and flags a 64K wrap.
      if (emit_c) begin
        rom_addr_q <= addr_q;
        rom_data_q <= emit_byte_c;
        prg_q      <= target_q;
        chr_q      <= ~target_q;
        addr_q     <= addr_q + ADDR_W'(1);
        if (addr_q == '1) begin
          wrap_q <= 1'b1;
        end
      end

      if (ctrl_wr_c) begin
        if (avl.AVL_WRITEDATA[4]) mirror_q  <= avl.AVL_WRITEDATA[2];
        if (avl.AVL_WRITEDATA[5]) chr_ram_q <= avl.AVL_WRITEDATA[3];
      end

      if (base_wr_c) begin
        addr_q   <= avl.AVL_WRITEDATA[ADDR_W-1:0];
        target_q <= avl.AVL_WRITEDATA[ADDR_W];
      end

      case (state_q)
        S_IDLE, S_RELEASE: begin
          if (data_wr_c) begin
            err_q <= 1'b1;
          end
          if (start_c) begin
            state_q <= S_LOADING;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
          end else if (state_q == S_RELEASE) begin
            if (rel_cnt_q == CNT_W'(1)) begin
              state_q <= S_IDLE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rel_cnt_q <= rel_cnt_q - CNT_W'(1);
            end
          end
        end
        S_LOADING: begin
          if (done_cmd_c) begin
            state_q   <= S_RELEASE;
            rel_cnt_q <= CNT_W'(RELEASE_DELAY);
          end else if (data_wr_c) begin
            word_q     <= avl.AVL_WRITEDATA;
            byte_idx_q <= 2'd0;
            state_q    <= S_DRAIN;
            waitreq_q  <= 1'b1;
          end
        end
        // byte_idx_q names the byte whose strobe is on the bus this cycle.
        S_DRAIN: begin
          if (byte_idx_q == 2'd3) begin
            state_q   <= S_LOADING;
            waitreq_q <= 1'b0;
          end else if (NO_GAP) begin
            byte_idx_q <= next_idx_c;
          end else begin
            state_q   <= S_GAP;
            gap_cnt_q <= GAP_W'(WR_GAP);
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q    <= S_DRAIN;
            byte_idx_q <= next_idx_c;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    avl.AVL_READDATA = '0;
    if (avl.AVL_CS && avl.AVL_READ) begin
      case (avl.AVL_ADDR)
        REG_CTRL: avl.AVL_READDATA = {27'd0, wrap_q, err_q, done_q, hold_q, (state_q != S_IDLE)};
        REG_BASE: avl.AVL_READDATA = {15'd0, target_q, addr_q};
        default:  avl.AVL_READDATA = '0;
      endcase
    end
  end

  assign avl.AVL_WAITREQUEST = waitreq_q;
  assign ROM_ADDR            = rom_addr_q;
  assign ROM_DATA            = rom_data_q;
  assign PRG_ROM_WRITE       = prg_q;
  assign CHR_ROM_WRITE       = chr_q;
  assign mirroring_mode      = mirror_q;
  assign is_chr_ram          = chr_ram_q;
  assign NES_HOLD            = hold_q;
  assign LOAD_DONE           = done_q;

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Avalon-MM slave that sequences cartridge image loading from the NIOS II into the NES PRG and CHR ROM blocks. It accepts packed 32-bit data words, serialises them into paced single-byte ROM write strobes with an auto-incrementing address, and latches cartridge configuration bits. It also holds the NES core (CPU/PPU) in reset for the whole load session and releases it after a programmable settling delay.

## Interface
Parameters:
- WR_GAP, 0: idle cycles inserted between consecutive byte strobes (0–15).
- RELEASE_DELAY, 16: cycles between a DONE command and deassertion of NES_HOLD (1–255).

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- AVL_ADDR  in  2  register select: 0 CTRL/STATUS, 1 BASE, 2 DATA, 3 reserved.
- AVL_CS  in  1  chip select.
- AVL_WRITE  in  1  write request.
- AVL_READ  in  1  read request.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, combinational, valid while AVL_CS & AVL_READ.
- AVL_WAITREQUEST  out  1  stall; high while the byte buffer is occupied.
- ROM_ADDR  out  16  ROM byte address.
- ROM_DATA  out  8  ROM byte data.
- PRG_ROM_WRITE  out  1  one-cycle PRG write strobe.
- CHR_ROM_WRITE  out  1  one-cycle CHR write strobe.
- mirroring_mode  out  1  nametable mirroring select.
- is_chr_ram  out  1  CHR is RAM (writable by the PPU).
- NES_HOLD  out  1  holds the NES core in reset.
- LOAD_DONE  out  1  high once a load session has completed.

## Operation
- States: IDLE, LOADING, DRAIN, GAP, RELEASE.
- An access is accepted when AVL_CS & (AVL_WRITE | AVL_READ) & !AVL_WAITREQUEST.
- CTRL write (addr 0) fields:
  - bit0 START: in IDLE or RELEASE, go to LOADING, set NES_HOLD=1 and LOAD_DONE=0, and clear ERR and WRAP. Ignored in LOADING.
  - bit1 DONE: in LOADING, go to RELEASE and load the delay counter with RELEASE_DELAY. Ignored elsewhere. If START and DONE are both set, START wins.
  - bit4=1: mirroring_mode <= bit2. bit5=1: is_chr_ram <= bit3. These apply in any state.
- STATUS read (addr 0): {27'b0, WRAP, ERR, LOAD_DONE, NES_HOLD, busy}. busy = state ∉ {IDLE}.
- BASE write (addr 1): addr_reg <= [15:0]; target <= [16] (1 = PRG, 0 = CHR). A BASE read returns {15'b0, target, addr_reg}.
- DATA write (addr 2):
  - In LOADING, latch the word and go to DRAIN. Bytes are emitted in the order [7:0], [15:8], [23:16], [31:24].
  - Outside LOADING the write is dropped and ERR is set (sticky).
- DRAIN: each byte drives ROM_ADDR=addr_reg and ROM_DATA=byte for one cycle, with exactly one strobe (the one matching target) high. addr_reg increments after each strobe.
- Between bytes, stay in GAP for WR_GAP cycles, or skip GAP when WR_GAP=0. After the 4th byte, return to LOADING.
- Address wrap: after 0xFFFF the address becomes 0x0000 and WRAP is set (sticky).
- RELEASE: the counter decrements each cycle. When it reaches 0: NES_HOLD=0, LOAD_DONE=1, state goes to IDLE.
- Reads of addr 3 return 0. Writes to addr 3 are ignored.

## Timing
- Reset values:
  - State IDLE, addr_reg 0, target 0.
  - Strobes 0, ROM_ADDR 0, ROM_DATA 0.
  - mirroring_mode 0, is_chr_ram 0.
  - NES_HOLD 1, LOAD_DONE 0, ERR 0, WRAP 0, AVL_WAITREQUEST 0.
- A reset in any state, including mid-drain, aborts immediately. A partially written word is not resumed.
- A DATA write accepted in cycle T produces byte k strobes at T+1+k·(WR_GAP+1), for k=0..3.
- AVL_WAITREQUEST is registered. It is high from T+1 through the last strobe cycle and low the following cycle. With WR_GAP=0 the next word is accepted at T+5.
- ROM_ADDR and ROM_DATA are stable for the entire strobe cycle. Strobes are never high outside DRAIN.
- START: NES_HOLD=1 and LOAD_DONE=0 from the cycle after acceptance.
- DONE accepted at T: NES_HOLD falls and LOAD_DONE rises at T+1+RELEASE_DELAY.
- START during RELEASE: NES_HOLD never drops.
- Config bit changes are visible the cycle after acceptance.

## Test plan
- Reset with RESET_N=0 for 2 cycles → NES_HOLD=1, all other outputs 0, STATUS reads 0x2.
- WR_GAP=0: START, then BASE=0x1_8000, then DATA=0x44332211 → PRG_ROM_WRITE pulses at addresses 0x8000–0x8003 with data 11, 22, 33, 44 on consecutive cycles. CHR_ROM_WRITE stays 0 and AVL_WAITREQUEST is high for 4 cycles.
- BASE=0x0_FFFE, then two DATA words → CHR writes at FFFE, FFFF, 0000, …, 0005. WRAP=1 in STATUS.
- DATA write while IDLE → no strobes, ERR=1. START then clears ERR.
- DONE with RELEASE_DELAY=16 → NES_HOLD falls exactly 17 cycles after acceptance and LOAD_DONE=1. A repeat run with START at delay cycle 8 → NES_HOLD stays 1 and the state is LOADING.
- CTRL=0x34 (set mirroring=1, is_chr_ram=0), then CTRL=0x28 → mirroring_mode=1 and is_chr_ram=1. A RESET_N pulse mid-DRAIN stops strobes on the next cycle.
